// File: rtl/stream_chunk_sequencer_pkg.sv
// rtl/stream_chunk_sequencer_pkg.sv - shared state encoding and step-count helpers
package stream_chunk_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    function automatic int calc_nfull(input int in_width, input int chunk_size);
        return in_width / chunk_size;
    endfunction

    function automatic int calc_rem(input int in_width, input int chunk_size);
        return in_width % chunk_size;
    endfunction

    function automatic int calc_nstep(input int in_width, input int chunk_size);
        return (in_width / chunk_size) + (((in_width % chunk_size) != 0) ? 1 : 0);
    endfunction

    function automatic int calc_cnt_width(input int nstep);
        return $clog2(nstep + 1);
    endfunction

endpackage

// File: rtl/stream_pad.sv
// rtl/stream_pad.sv - combinational msb-aligned pad/truncate from IN_WIDTH to OUT_WIDTH
module stream_pad #(
    parameter int IN_WIDTH  = 16,
    parameter int OUT_WIDTH = 16
) (
    input  logic [IN_WIDTH-1:0]  data,
    output logic [OUT_WIDTH-1:0] padded
);

    generate
        if (IN_WIDTH > OUT_WIDTH) begin : g_trunc
            assign padded = data[IN_WIDTH-1 -: OUT_WIDTH];
        end else if (IN_WIDTH == OUT_WIDTH) begin : g_same
            assign padded = data;
        end else begin : g_pad
            assign padded = {data, {(OUT_WIDTH-IN_WIDTH){1'b0}}};
        end
    endgenerate

endmodule

// File: rtl/stream_chunk_sequencer.sv
// rtl/stream_chunk_sequencer.sv - serial chunk-reversing / pass-through streamer, one slice per clock
module stream_chunk_sequencer
    import stream_chunk_sequencer_pkg::*;
#(
    parameter int IN_WIDTH   = 16,
    parameter int OUT_WIDTH  = 16,
    parameter int CHUNK_SIZE = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_dir,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 busy
);

    localparam int NFULL = calc_nfull(IN_WIDTH, CHUNK_SIZE);
    localparam int REM   = calc_rem(IN_WIDTH, CHUNK_SIZE);
    localparam int NSTEP = calc_nstep(IN_WIDTH, CHUNK_SIZE);
    localparam int CW    = calc_cnt_width(NSTEP);
    // Masks for the short trailing slice; both are zero when the width divides evenly.
    localparam logic [IN_WIDTH-1:0] REM_LO = {IN_WIDTH{1'b1}} >> (IN_WIDTH - REM);
    localparam logic [IN_WIDTH-1:0] REM_HI = REM_LO << (NFULL * CHUNK_SIZE);

    seq_state_t            state;
    logic [CW-1:0]         step;
    logic [IN_WIDTH-1:0]   src;
    logic                  dir;
    logic [IN_WIDTH-1:0]   result;
    logic [IN_WIDTH-1:0]   result_next;
    logic [OUT_WIDTH-1:0]  pad_data;

    always_comb begin
        result_next = result;
        for (int i = 0; i < NFULL; i++) begin
            if (step == CW'(i)) begin
                if (dir)
                    result_next[i*CHUNK_SIZE +: CHUNK_SIZE] = src[i*CHUNK_SIZE +: CHUNK_SIZE];
                else
                    result_next[IN_WIDTH-1-i*CHUNK_SIZE -: CHUNK_SIZE] = src[i*CHUNK_SIZE +: CHUNK_SIZE];
            end
        end
        if (REM != 0 && step == CW'(NFULL)) begin
            if (dir)
                result_next = (result & ~REM_HI) | (src & REM_HI);
            else
                result_next = (result & ~REM_LO) | ((src >> (NFULL * CHUNK_SIZE)) & REM_LO);
        end
    end

    // Pad the in-flight value so out_data is registered on the same edge the last slice lands.
    stream_pad #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_pad (
        .data   (result_next),
        .padded (pad_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            src       <= '0;
            dir       <= 1'b0;
            result    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src      <= in_data;
                        dir      <= in_dir;
                        result   <= '0;
                        step     <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    if (abort) begin
                        state    <= IDLE;
                        result   <= '0;
                        step     <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        result <= result_next;
                        step   <= step + CW'(1);
                        if (step == CW'(NSTEP - 1)) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= pad_data;
                        end
                    end
                end
                DONE: begin
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_chunk_sequencer.sv
// tb/tb_stream_chunk_sequencer.sv - directed self-checking bench over five parameter sets
module tb_stream_chunk_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_dir = 1'b0;
    logic        abort = 1'b0;
    logic [4:0]  iv = '0;
    logic [4:0]  orr = '0;
    logic [4:0]  ir;
    logic [4:0]  ov;
    logic [4:0]  bz;
    logic [15:0] in0 = '0;
    logic [9:0]  in1 = '0;
    logic [9:0]  in2 = '0;
    logic [7:0]  in3 = '0;
    logic [7:0]  in4 = '0;
    logic [15:0] out0;
    logic [11:0] out1;
    logic [7:0]  out2;
    logic [7:0]  out3;
    logic [7:0]  out4;
    int          ncmp = 0;
    int          nfail = 0;

    always #5 clk = ~clk;

    stream_chunk_sequencer #(.IN_WIDTH(16), .OUT_WIDTH(16), .CHUNK_SIZE(4)) d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(in0), .in_dir(in_dir),
        .abort(abort), .out_valid(ov[0]), .out_ready(orr[0]), .out_data(out0), .busy(bz[0]));
    stream_chunk_sequencer #(.IN_WIDTH(10), .OUT_WIDTH(12), .CHUNK_SIZE(4)) d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(in1), .in_dir(in_dir),
        .abort(abort), .out_valid(ov[1]), .out_ready(orr[1]), .out_data(out1), .busy(bz[1]));
    stream_chunk_sequencer #(.IN_WIDTH(10), .OUT_WIDTH(8), .CHUNK_SIZE(4)) d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(in2), .in_dir(in_dir),
        .abort(abort), .out_valid(ov[2]), .out_ready(orr[2]), .out_data(out2), .busy(bz[2]));
    stream_chunk_sequencer #(.IN_WIDTH(8), .OUT_WIDTH(8), .CHUNK_SIZE(1)) d3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .in_data(in3), .in_dir(in_dir),
        .abort(abort), .out_valid(ov[3]), .out_ready(orr[3]), .out_data(out3), .busy(bz[3]));
    stream_chunk_sequencer #(.IN_WIDTH(8), .OUT_WIDTH(8), .CHUNK_SIZE(8)) d4 (
        .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .in_data(in4), .in_dir(in_dir),
        .abort(abort), .out_valid(ov[4]), .out_ready(orr[4]), .out_data(out4), .busy(bz[4]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int idx, input logic [15:0] din);
        case (idx)
            0: in0 = din;
            1: in1 = din[9:0];
            2: in2 = din[9:0];
            3: in3 = din[7:0];
            default: in4 = din[7:0];
        endcase
    endtask

    function automatic logic [31:0] get_out(input int idx);
        case (idx)
            0: return {16'h0, out0};
            1: return {20'h0, out1};
            2: return {24'h0, out2};
            3: return {24'h0, out3};
            default: return {24'h0, out4};
        endcase
    endfunction

    task automatic run(input int idx, input int nstep, input logic [15:0] din, input logic dir,
                       input logic [31:0] exp, input string tag);
        @(negedge clk);
        set_in(idx, din);
        in_dir = dir;
        iv[idx] = 1'b1;
        @(negedge clk);
        iv[idx] = 1'b0;
        set_in(idx, ~din);
        in_dir = ~dir;
        check({tag, "_busy"}, {31'h0, bz[idx]}, 32'h1);
        check({tag, "_inrdy_low"}, {31'h0, ir[idx]}, 32'h0);
        for (int i = 1; i <= nstep; i++) begin
            @(negedge clk);
            if (i < nstep) check({tag, "_early_valid"}, {31'h0, ov[idx]}, 32'h0);
        end
        check({tag, "_valid"}, {31'h0, ov[idx]}, 32'h1);
        check({tag, "_data"}, get_out(idx), exp);
        orr[idx] = 1'b1;
        @(negedge clk);
        orr[idx] = 1'b0;
        check({tag, "_valid_drop"}, {31'h0, ov[idx]}, 32'h0);
        check({tag, "_idle_rdy"}, {31'h0, ir[idx]}, 32'h1);
        check({tag, "_data_kept"}, get_out(idx), exp);
    endtask

    initial begin
        // reset state of every instance
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {27'h0, ir}, 32'h1f);
        check("rst_out_valid", {27'h0, ov}, 32'h0);
        check("rst_busy", {27'h0, bz}, 32'h0);
        check("rst_out0", get_out(0), 32'h0);
        check("rst_out1", get_out(1), 32'h0);

        run(0, 4, 16'h1234, 1'b0, 32'h4321, "d0_left");
        run(1, 3, 16'h0359, 1'b0, 32'h095c, "d1_left_pad");
        run(2, 3, 16'h0359, 1'b0, 32'h0095, "d2_left_trunc");
        run(1, 3, 16'h0359, 1'b1, 32'h0d64, "d1_right_pad");
        run(3, 8, 16'h00ca, 1'b0, 32'h0053, "d3_bitrev");
        run(3, 8, 16'h00ca, 1'b1, 32'h00ca, "d3_right");
        run(4, 1, 16'h00ca, 1'b0, 32'h00ca, "d4_whole");

        // consumer back-pressure with producer holding in_valid
        @(negedge clk);
        set_in(1, 16'h0359);
        in_dir = 1'b0;
        iv[1] = 1'b1;
        @(negedge clk);
        set_in(1, 16'h00a5);
        repeat (3) @(negedge clk);
        check("hold_valid_rise", {31'h0, ov[1]}, 32'h1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", {31'h0, ov[1]}, 32'h1);
            check("hold_data", get_out(1), 32'h095c);
            check("hold_no_accept", {31'h0, ir[1]}, 32'h0);
        end
        orr[1] = 1'b1;
        @(negedge clk);
        orr[1] = 1'b0;
        check("hold_release_valid", {31'h0, ov[1]}, 32'h0);
        check("hold_release_busy", {31'h0, bz[1]}, 32'h0);
        @(negedge clk);
        iv[1] = 1'b0;
        check("hold_reaccept", {31'h0, bz[1]}, 32'h1);
        repeat (3) @(negedge clk);
        // 0x0a5 left: slices 5,a,0 -> 0101_1010_00 = 0x168, padded 0x5a0
        check("hold_second_data", get_out(1), 32'h05a0);
        orr[1] = 1'b1;
        @(negedge clk);
        orr[1] = 1'b0;

        // abort at step 1
        @(negedge clk);
        set_in(0, 16'hbeef);
        in_dir = 1'b0;
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", {31'h0, ov[0]}, 32'h0);
        check("abort_rdy", {31'h0, ir[0]}, 32'h1);
        check("abort_busy", {31'h0, bz[0]}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("abort_no_pulse", {31'h0, ov[0]}, 32'h0);
        end

        // reset mid-transaction
        set_in(0, 16'h5a5a);
        iv[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_rdy", {31'h0, ir[0]}, 32'h1);
        check("midrst_busy", {31'h0, bz[0]}, 32'h0);
        check("midrst_out0", get_out(0), 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("midrst_no_pulse", {31'h0, ov[0]}, 32'h0);
        end

        // abort in IDLE is ignored, abort beats out_ready in DONE
        abort = 1'b1;
        set_in(4, 16'h003c);
        in_dir = 1'b0;
        iv[4] = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        iv[4] = 1'b0;
        check("idle_abort_accept", {31'h0, bz[4]}, 32'h1);
        @(negedge clk);
        check("idle_abort_valid", {31'h0, ov[4]}, 32'h1);
        check("idle_abort_data", get_out(4), 32'h003c);
        abort = 1'b1;
        orr[4] = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        orr[4] = 1'b0;
        check("done_abort_valid", {31'h0, ov[4]}, 32'h0);
        check("done_abort_rdy", {31'h0, ir[4]}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
